result_unloader: RTL

RESULT_UNLOADER -- requirements
Module: result_unloader

---
 rtl/result_unloader.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/result_unloader.sv
// Streams a row-major result matrix out of the data RAM, one word per READ/WAIT/SEND pass.
// Optional running word checksum on CHECKSUM when RESULT_CHECKSUM_EN is defined.
module result_unloader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 8
) (
    input  logic              MAIN_CLOCK,
    input  logic              RESET_N,
    input  logic              START,
    input  logic [ADDR_W-1:0] RESULT_BASE,
    input  logic [DIM_W-1:0]  ROWS,
    input  logic [DIM_W-1:0]  COLS,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic              RAM_RD_EN,
    input  logic [DATA_W-1:0] RAM_DATA,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic              OUT_LAST,
    output logic [DIM_W-1:0]  OUT_ROW,
    output logic [DIM_W-1:0]  OUT_COL,
    output logic              BUSY,
    output logic              DONE,
    output logic [DATA_W-1:0] CHECKSUM
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_SEND,
        ST_FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DIM_W-1:0]  row_q, row_d;
    logic [DIM_W-1:0]  col_q, col_d;
    logic [DIM_W-1:0]  rows_q, rows_d;
    logic [DIM_W-1:0]  cols_q, cols_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;

    logic start_accept;
    logic handshake;
    logic col_at_end;
    logic row_at_end;

    assign start_accept = (state_q == ST_IDLE) && START;
    assign handshake    = (state_q == ST_SEND) && OUT_READY;
    assign col_at_end   = (col_q == cols_q - DIM_W'(1));
    assign row_at_end   = (row_q == rows_q - DIM_W'(1));

    always_ff @(posedge MAIN_CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            rows_q  <= '0;
            cols_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            row_q   <= row_d;
            col_q   <= col_d;
            rows_q  <= rows_d;
            cols_q  <= cols_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        row_d   = row_q;
        col_d   = col_q;
        rows_d  = rows_q;
        cols_d  = cols_q;
        data_d  = data_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    rows_d = ROWS;
                    cols_d = COLS;
                    ptr_d  = RESULT_BASE;
                    row_d  = '0;
                    col_d  = '0;
                    last_d = 1'b0;
                    // An empty matrix still reports completion, just without any reads.
                    if ((ROWS == '0) || (COLS == '0)) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                data_d  = RAM_DATA;
                last_d  = row_at_end && col_at_end;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (OUT_READY) begin
                    if (last_q) begin
                        state_d = ST_FINISH;
                    end else begin
                        ptr_d   = ptr_q + ADDR_W'(1);
                        state_d = ST_READ;
                        if (col_at_end) begin
                            col_d = '0;
                            row_d = row_q + DIM_W'(1);
                        end else begin
                            col_d = col_q + DIM_W'(1);
                        end
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef RESULT_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (start_accept) begin
            sum_d = '0;
        end else if (handshake) begin
            sum_d = sum_q + data_q;
        end
    end

    always_ff @(posedge MAIN_CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign CHECKSUM = sum_q;
`else
    assign CHECKSUM = '0;
`endif

    assign RAM_ADDR  = ptr_q;
    assign RAM_RD_EN = (state_q == ST_READ);
    assign OUT_DATA  = data_q;
    assign OUT_VALID = (state_q == ST_SEND);
    assign OUT_LAST  = (state_q == ST_SEND) && last_q;
    assign OUT_ROW   = row_q;
    assign OUT_COL   = col_q;
    assign BUSY      = (state_q != ST_IDLE);
    assign DONE      = (state_q == ST_FINISH);

endmodule
